// File: rtl/tour_cmd_seq_if.sv
// Command-path bundle between the UART wrapper, the tour solver memory,
// cmd_proc and tour_cmd_seq. The slave modport is the sequencer's view.
interface tour_cmd_seq_if;
   logic        start_tour;
   logic [7:0]  move;
   logic [4:0]  mv_indx;
   logic [15:0] cmd_UART;
   logic        cmd_rdy_UART;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic        send_resp;
   logic [7:0]  resp;

   modport master (
      output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
      input  mv_indx, cmd, cmd_rdy, resp
   );

   modport slave (
      input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
      output mv_indx, cmd, cmd_rdy, resp
   );
endinterface

// File: rtl/tour_cmd_seq.sv
// tour_cmd_seq: forwards UART commands to cmd_proc while idle; during a tour
// it splits each one-hot knight move into a vertical leg (opcode 4) and a
// horizontal leg (opcode 5) and sequences them through the cmd_proc handshake.
// Optional feature macro: TOUR_ABORT_EN (a UART command aborts a running tour).
module tour_cmd_seq #(
   parameter int unsigned NUM_MOVES = 24
) (
   input  logic         clk,
   input  logic         rst_n,
   tour_cmd_seq_if.slave bus
);

   localparam int unsigned IDX_W = 5;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

   localparam logic [3:0] OP_MOVE    = 4'h4;
   localparam logic [3:0] OP_FANFARE = 4'h5;
   localparam logic [7:0] HDG_N      = 8'h00;
   localparam logic [7:0] HDG_W      = 8'h3F;
   localparam logic [7:0] HDG_S      = 8'h7F;
   localparam logic [7:0] HDG_E      = 8'hBF;
   localparam logic [7:0] RESP_BUSY  = 8'h5A;
   localparam logic [7:0] RESP_DONE  = 8'hA5;

`ifdef TOUR_ABORT_EN
   localparam logic ABORT_EN = 1'b1;
`else
   localparam logic ABORT_EN = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, VERT, HOLD_V, HORZ, HOLD_H} state_t;

   typedef struct packed {
      logic [3:0] opcode;
      logic [7:0] heading;
      logic [3:0] squares;
   } cmd_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] mv_indx_q, mv_indx_d;
   logic [7:0]       resp_q, resp_d;
   logic             send_pend_q, send_pend_d;

   logic             vert_north, horz_east;
   logic [3:0]       vert_sq, horz_sq;
   cmd_t             vert_cmd, horz_cmd;
   logic [15:0]      cmd_c;
   logic             cmd_rdy_c;
   logic             last_move;

   assign last_move = (mv_indx_q == LAST_IDX);

   // Decode the one-hot move into leg directions and lengths; anything else acts as b0.
   always_comb begin
      vert_north = 1'b1;
      vert_sq    = 4'd2;
      horz_east  = 1'b0;
      horz_sq    = 4'd1;
      case (bus.move)
         8'h02: begin vert_north = 1'b1; vert_sq = 4'd2; horz_east = 1'b1; horz_sq = 4'd1; end
         8'h04: begin vert_north = 1'b1; vert_sq = 4'd1; horz_east = 1'b0; horz_sq = 4'd2; end
         8'h08: begin vert_north = 1'b0; vert_sq = 4'd1; horz_east = 1'b0; horz_sq = 4'd2; end
         8'h10: begin vert_north = 1'b0; vert_sq = 4'd2; horz_east = 1'b0; horz_sq = 4'd1; end
         8'h20: begin vert_north = 1'b0; vert_sq = 4'd2; horz_east = 1'b1; horz_sq = 4'd1; end
         8'h40: begin vert_north = 1'b0; vert_sq = 4'd1; horz_east = 1'b1; horz_sq = 4'd2; end
         8'h80: begin vert_north = 1'b1; vert_sq = 4'd1; horz_east = 1'b1; horz_sq = 4'd2; end
         default: ;
      endcase
   end

   // Assemble the two leg commands.
   always_comb begin
      vert_cmd.opcode  = OP_MOVE;
      vert_cmd.heading = vert_north ? HDG_N : HDG_S;
      vert_cmd.squares = vert_sq;
      horz_cmd.opcode  = OP_FANFARE;
      horz_cmd.heading = horz_east ? HDG_E : HDG_W;
      horz_cmd.squares = horz_sq;
   end

   // Next-state, counter, response and command mux.
   always_comb begin
      state_d     = state_q;
      mv_indx_d   = mv_indx_q;
      resp_d      = resp_q;
      send_pend_d = 1'b0;
      cmd_c       = bus.cmd_UART;
      cmd_rdy_c   = 1'b0;

      if (bus.send_resp) begin
         resp_d = ((state_q != IDLE) && !((state_q == HOLD_H) && last_move))
                  ? RESP_BUSY : RESP_DONE;
      end

      case (state_q)
         IDLE: begin
            cmd_rdy_c = bus.cmd_rdy_UART;
            if (bus.start_tour) begin
               mv_indx_d = '0;
               state_d   = VERT;
            end
         end
         VERT: begin
            cmd_c     = vert_cmd;
            cmd_rdy_c = 1'b1;
            if (bus.clr_cmd_rdy) begin
               state_d     = HOLD_V;
               // a send_resp arriving with the accept must not be dropped
               send_pend_d = bus.send_resp;
            end
         end
         HOLD_V: begin
            cmd_c = vert_cmd;
            if (bus.send_resp || send_pend_q) state_d = HORZ;
         end
         HORZ: begin
            cmd_c     = horz_cmd;
            cmd_rdy_c = 1'b1;
            if (bus.clr_cmd_rdy) state_d = HOLD_H;
         end
         HOLD_H: begin
            cmd_c = horz_cmd;
            if (bus.send_resp) begin
               if (last_move) begin
                  state_d = IDLE;
               end else begin
                  mv_indx_d = mv_indx_q + IDX_W'(1);
                  state_d   = VERT;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (ABORT_EN && (state_q != IDLE) && bus.cmd_rdy_UART) begin
         state_d     = IDLE;
         mv_indx_d   = '0;
         resp_d      = RESP_DONE;
         send_pend_d = 1'b0;
      end
   end

   // State, move counter, response and pending-send registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mv_indx_q   <= '0;
         resp_q      <= RESP_DONE;
         send_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mv_indx_q   <= mv_indx_d;
         resp_q      <= resp_d;
         send_pend_q <= send_pend_d;
      end
   end

   assign bus.cmd     = cmd_c;
   assign bus.cmd_rdy = cmd_rdy_c;
   assign bus.mv_indx = mv_indx_q;
   assign bus.resp    = resp_q;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Scoreboard bench for tour_cmd_seq: stimulus pushes expected commands,
// a negedge monitor pops and compares each command cmd_proc accepts.
module tb_tour_cmd_seq;

   logic clk;
   logic rst_n;
   tour_cmd_seq_if bus();

   tour_cmd_seq #(.NUM_MOVES(24)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   int          pops   = 0;
   logic [15:0] exp_q[$];

   int dy_tbl[8] = '{2, 2, 1, -1, -2, -2, -1, 1};
   int dx_tbl[8] = '{-1, 1, -2, -2, -1, 1, 2, 2};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] vcmd(input int dy);
      logic [3:0] sq;
      sq = 4'((dy < 0) ? -dy : dy);
      return {4'h4, (dy > 0) ? 8'h00 : 8'h7F, sq};
   endfunction

   function automatic logic [15:0] hcmd(input int dx);
      logic [3:0] sq;
      sq = 4'((dx < 0) ? -dx : dx);
      return {4'h5, (dx > 0) ? 8'hBF : 8'h3F, sq};
   endfunction

   // Monitor: every accepted command must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && bus.cmd_rdy && bus.clr_cmd_rdy) begin
         if (exp_q.size() == 0) begin
            check("unexpected_cmd", 32'(bus.cmd), 32'hFFFF_FFFF);
         end else begin
            check("cmd", 32'(bus.cmd), 32'(exp_q.pop_front()));
            pops++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n            = 1'b0;
      bus.start_tour   = 1'b0;
      bus.move         = 8'h01;
      bus.cmd_UART     = 16'h0000;
      bus.cmd_rdy_UART = 1'b0;
      bus.clr_cmd_rdy  = 1'b0;
      bus.send_resp    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_rdy();
      int n = 0;
      while (!bus.cmd_rdy && n < 20) begin
         tick();
         n++;
      end
      if (!bus.cmd_rdy) check("cmd_rdy_timeout", 32'(bus.cmd_rdy), 32'd1);
   endtask

   task automatic pulse_start();
      bus.start_tour = 1'b1;
      tick();
      bus.start_tour = 1'b0;
   endtask

   // cmd_proc model: accept one leg, hold a few cycles, then respond.
   task automatic do_leg(input logic [15:0] exp, input int hold);
      exp_q.push_back(exp);
      wait_rdy();
      bus.clr_cmd_rdy = 1'b1;
      tick();
      bus.clr_cmd_rdy = 1'b0;
      repeat (hold) tick();
      bus.send_resp = 1'b1;
      tick();
      bus.send_resp = 1'b0;
   endtask

   task automatic run_moves(input int n);
      for (int i = 0; i < n; i++) begin
         int b;
         b = (i * 3) % 8;
         bus.move = 8'h01 << b;
         check("mv_indx_step", 32'(bus.mv_indx), 32'(i));
         do_leg(vcmd(dy_tbl[b]), i % 3);
         do_leg(hcmd(dx_tbl[b]), 1);
      end
   endtask

   logic [7:0]  sweep_mv [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00, 8'h81};
   logic [15:0] sweep_v  [10] = '{16'h4002, 16'h4002, 16'h4001, 16'h47F1, 16'h47F2, 16'h47F2, 16'h47F1, 16'h4001, 16'h4002, 16'h4002};
   logic [15:0] sweep_h  [10] = '{16'h53F1, 16'h5BF1, 16'h53F2, 16'h53F2, 16'h53F1, 16'h5BF1, 16'h5BF2, 16'h5BF2, 16'h53F1, 16'h53F1};

   initial begin
      do_reset();

      // reset state
      check("rst_mv_indx", 32'(bus.mv_indx), 32'd0);
      check("rst_resp", 32'(bus.resp), 32'hA5);
      check("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);

      // UART passthrough
      bus.cmd_UART     = 16'h4001;
      bus.cmd_rdy_UART = 1'b1;
      bus.clr_cmd_rdy  = 1'b1;
      exp_q.push_back(16'h4001);
      #1;
      check("pass_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
      tick();
      bus.cmd_rdy_UART = 1'b0;
      bus.clr_cmd_rdy  = 1'b0;
      check("pass_resp", 32'(bus.resp), 32'hA5);

      // single leg pair with latency check
      bus.move = 8'h02;
      pulse_start();
      check("start_latency", 32'(bus.cmd_rdy), 32'd1);
      do_leg(16'h4002, 0);
      do_leg(16'h5BF1, 2);
      check("pair_mv_indx", 32'(bus.mv_indx), 32'd1);
      check("pair_resp", 32'(bus.resp), 32'h5A);

      // decode sweep including non-one-hot moves
      for (int i = 0; i < 10; i++) begin
         do_reset();
         bus.move = sweep_mv[i];
         pulse_start();
         do_leg(sweep_v[i], 1);
         do_leg(sweep_h[i], 0);
      end

      // full tour
      do_reset();
      pops = 0;
      pulse_start();
      run_moves(23);
      check("pre_last_resp", 32'(bus.resp), 32'h5A);
      begin
         int b;
         b = (23 * 3) % 8;
         bus.move = 8'h01 << b;
         check("mv_indx_step", 32'(bus.mv_indx), 32'd23);
         do_leg(vcmd(dy_tbl[b]), 0);
         do_leg(hcmd(dx_tbl[b]), 0);
      end
      check("tour_cmd_count", 32'(pops), 32'd48);
      check("tour_end_mv_indx", 32'(bus.mv_indx), 32'd23);
      check("tour_end_resp", 32'(bus.resp), 32'hA5);
      for (int i = 0; i < 4; i++) begin
         check("tour_end_no_rdy", 32'(bus.cmd_rdy), 32'd0);
         tick();
      end
      pulse_start();
      check("restart_mv_indx", 32'(bus.mv_indx), 32'd0);

      // handshake corner: clr and send together in VERT, start ignored in HOLD_V
      do_reset();
      bus.move = 8'h02;
      pulse_start();
      pulse_start();
      exp_q.push_back(16'h4002);
      wait_rdy();
      bus.clr_cmd_rdy = 1'b1;
      bus.send_resp   = 1'b1;
      tick();
      bus.clr_cmd_rdy = 1'b0;
      bus.send_resp   = 1'b0;
      bus.start_tour  = 1'b1;
      check("corner_hold_v_rdy", 32'(bus.cmd_rdy), 32'd0);
      tick();
      bus.start_tour = 1'b0;
      check("corner_horz_rdy", 32'(bus.cmd_rdy), 32'd1);
      check("corner_horz_cmd", 32'(bus.cmd), 32'h5BF1);
      do_leg(16'h5BF1, 0);
      check("corner_mv_indx", 32'(bus.mv_indx), 32'd1);

      // reset mid-tour at mv_indx 7 in HORZ
      do_reset();
      pulse_start();
      run_moves(7);
      bus.move = 8'h01;
      do_leg(16'h4002, 0);
      wait_rdy();
      check("mid_mv_indx", 32'(bus.mv_indx), 32'd7);
      check("mid_resp", 32'(bus.resp), 32'h5A);
      rst_n = 1'b0;
      #2;
      check("midrst_mv_indx", 32'(bus.mv_indx), 32'd0);
      check("midrst_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
      check("midrst_resp", 32'(bus.resp), 32'hA5);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // UART command while in HOLD_V
      do_reset();
      pulse_start();
      run_moves(7);
      bus.move = 8'h01;
      exp_q.push_back(16'h4002);
      wait_rdy();
      bus.clr_cmd_rdy = 1'b1;
      tick();
      bus.clr_cmd_rdy  = 1'b0;
      bus.cmd_UART     = 16'h4123;
      bus.cmd_rdy_UART = 1'b1;
      tick();
      bus.cmd_rdy_UART = 1'b0;
`ifdef TOUR_ABORT_EN
      check("abort_mv_indx", 32'(bus.mv_indx), 32'd0);
      check("abort_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
      check("abort_resp", 32'(bus.resp), 32'hA5);
`else
      check("noabort_mv_indx", 32'(bus.mv_indx), 32'd7);
      check("noabort_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
      check("noabort_resp", 32'(bus.resp), 32'h5A);
      bus.send_resp = 1'b1;
      tick();
      bus.send_resp = 1'b0;
      do_leg(16'h53F1, 0);
      check("noabort_next_mv", 32'(bus.mv_indx), 32'd8);
`endif

      repeat (2) tick();
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tour_cmd_seq.md
Name: tour_cmd_seq

Overview:
Sits between the UART command wrapper and cmd_proc inside KnightsTour. In normal mode it passes UART-received 16-bit commands straight to cmd_proc. When a tour is started, it takes over the command path. It reads the solved tour one move at a time and splits each knight move into two cmd_proc commands: a vertical leg, then a horizontal leg. It then sequences these commands through the cmd_proc handshake and drives the response byte returned to the remote.

Parameters:
NUM_MOVES, 24, number of knight moves in a tour; mv_indx counts 0..NUM_MOVES-1.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start_tour  input  1  one-cycle pulse from cmd_proc; begins the tour at mv_indx 0
move  input  8  one-hot move for the current mv_indx (from tour solver memory)
mv_indx  output  5  index of the move being executed
cmd_UART  input  16  command from the UART wrapper
cmd_rdy_UART  input  1  UART command valid
cmd  output  16  command to cmd_proc
cmd_rdy  output  1  command valid to cmd_proc
clr_cmd_rdy  input  1  cmd_proc has accepted cmd
send_resp  input  1  cmd_proc finished the current command
resp  output  8  response byte to the UART wrapper

Behaviour:
- Command format: [15:12] opcode, [11:4] heading, [3:0] squares.
  - Opcodes: 4 = move, 5 = move with fanfare.
  - Headings: 8'h00 N, 8'h3F W, 8'h7F S, 8'hBF E.
- Move decode (bit: dy, dx):
  - b0: +2,-1
  - b1: +2,+1
  - b2: +1,-2
  - b3: -1,-2
  - b4: -2,-1
  - b5: -2,+1
  - b6: -1,+2
  - b7: +1,+2
- Vertical leg: opcode 4, heading N if dy>0 else S, squares = |dy|.
- Horizontal leg: opcode 5, heading E if dx>0 else W, squares = |dx|.
- move is not one-hot (0 or multiple bits set): treat as b0 (decoder default).
- FSM states: IDLE, VERT, HOLD_V, HORZ, HOLD_H.
  - IDLE: cmd = cmd_UART, cmd_rdy = cmd_rdy_UART. start_tour -> clear mv_indx to 0, go to VERT.
  - VERT: cmd = vertical leg, cmd_rdy = 1. On clr_cmd_rdy go to HOLD_V.
  - HOLD_V: cmd_rdy = 0. On send_resp go to HORZ.
  - HORZ: cmd = horizontal leg, cmd_rdy = 1. On clr_cmd_rdy go to HOLD_H.
  - HOLD_H: cmd_rdy = 0. On send_resp:
    - if mv_indx == NUM_MOVES-1, go to IDLE;
    - else increment mv_indx and go to VERT.
- Outside IDLE, cmd_UART and cmd_rdy_UART are ignored. cmd is held stable through each HOLD state.
- mv_indx is a registered counter. It increments only on HOLD_H & send_resp when not the last move, and never wraps past NUM_MOVES-1. The move input is sampled combinationally from the current mv_indx.
- resp:
  - 8'h5A in any non-IDLE state unless mv_indx == NUM_MOVES-1 and state is HOLD_H.
  - 8'hA5 otherwise, i.e. in IDLE and on the final leg's completion.
  - Value is registered on send_resp.
- clr_cmd_rdy and send_resp in the same cycle while in VERT: only the clr_cmd_rdy transition is taken; send_resp is not lost and is honoured the next cycle in HOLD_V.
- start_tour while not IDLE: ignored.
- Reset (asynchronous, any time including mid-tour):
  - state = IDLE, mv_indx = 0, resp = 8'hA5.
  - cmd follows cmd_UART and cmd_rdy follows cmd_rdy_UART (both low after reset, since the UART wrapper also resets).
- Latency: cmd_rdy rises the cycle after start_tour, and the cycle after the send_resp that closes the previous leg.

Optional Feature:
TOUR_ABORT_EN:
- Defined: a cmd_rdy_UART pulse in any non-IDLE state aborts the tour. The block returns to IDLE next cycle with mv_indx = 0, cmd_rdy drops, and resp = 8'hA5. The UART command is then forwarded normally.
- Undefined: UART commands are ignored until the tour completes.

Test Plan:
- UART passthrough: reset, cmd_UART = 16'h4001, cmd_rdy_UART = 1 -> cmd = 16'h4001, cmd_rdy = 1 the same cycle; resp = 8'hA5.
- Single leg pair: start_tour with move = 8'h02 -> cmd = 16'h4002. After clr_cmd_rdy and send_resp -> cmd = 16'h5BF1. After send_resp -> mv_indx = 1, resp = 8'h5A.
- Move decode sweep: step through all 8 one-hot moves -> vertical/horizontal pairs 4002/53F1, 4002/5BF1, 4001/53F2, 47F1/53F2, 47F2/53F1, 47F2/5BF1, 47F1/5BF2, 4001/5BF2.
- Full tour: 24 moves with auto-responding cmd_proc model -> 48 commands issued, mv_indx ends at 23, then 0 after the next start_tour; final resp = 8'hA5; no cmd_rdy after the last leg.
- Handshake corner: clr_cmd_rdy and send_resp asserted together in VERT -> single HOLD_V visit, then HORZ next cycle; start_tour during HOLD_V ignored.
- Reset mid-tour at mv_indx = 7 in HORZ -> state IDLE, mv_indx = 0, cmd_rdy = 0, resp = 8'hA5. With TOUR_ABORT_EN defined, cmd_rdy_UART in HOLD_V gives the same result.
